// File: rtl/regfile_2r1w_clr_if.sv
// Bus between the decode stage and the register file: one write port,
// two read-address ports, two registered read-data ports, and busy.
//
// Handshake: there is no valid/ready pair on this bus. The master drives
// we/Rw/din/Ra/Rb, and the slave samples them at every posedge. While busy is
// high the slave ignores we/Rw/din and drops them (no queueing), and it returns
// 0 on doutA/doutB. Read data always appears one posedge after its address is
// sampled.
interface regfile_2r1w_clr_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) ();
  logic              we;
  logic [ADDR_W-1:0] Rw;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] Ra;
  logic [ADDR_W-1:0] Rb;
  logic [DATA_W-1:0] doutA;
  logic [DATA_W-1:0] doutB;
  logic              busy;

  modport master (
    output we, Rw, din, Ra, Rb,
    input  doutA, doutB, busy
  );

  modport slave (
    input  we, Rw, din, Ra, Rb,
    output doutA, doutB, busy
  );
endinterface

// File: rtl/regfile_2r1w_clr.sv
// 2-read/1-write register file with registered reads. Entry 0 can optionally
// be hardwired to zero. Write data can optionally be bypassed to a read of the
// same entry in the same cycle. After reset, a clear sequencer zeroes every
// entry, one entry per clock, before normal operation starts.
module regfile_2r1w_clr #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_2r1w_clr_if.slave   bus,
  output logic                dbg_state_o   // 0: CLEAR, 1: READY
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_a_q, dout_a_d;
  logic [DATA_W-1:0] dout_b_q, dout_b_d;

  logic              busy;
  logic              wr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // State register: the sequencer restarts at entry 0 on every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: walk clr_ptr to the last entry, then stay in READY until reset.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == S_CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_PTR) begin
        state_d = S_READY;
      end
    end
  end

  // Outputs: busy plus one write port, which the sequencer and the bus share.
  always_comb begin
    busy      = (state_q == S_CLEAR);
    wr_ok     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.Rw;
    mem_wdata = bus.din;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else begin
      // Entry 0 silently drops writes when it is hardwired to zero.
      wr_ok  = bus.we & ~(ZERO_REG & (bus.Rw == '0));
      mem_we = wr_ok;
    end
  end

  // Storage array: not reset, because the sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read-data selection per port: zero register, then bypass, then the array.
  always_comb begin
    dout_a_d = '0;
    dout_b_d = '0;
    if (!busy) begin
      if (ZERO_REG && (bus.Ra == '0)) begin
        dout_a_d = '0;
      end else if (BYPASS && wr_ok && (bus.Rw == bus.Ra)) begin
        dout_a_d = bus.din;
      end else begin
        dout_a_d = mem_q[bus.Ra];
      end
      if (ZERO_REG && (bus.Rb == '0)) begin
        dout_b_d = '0;
      end else if (BYPASS && wr_ok && (bus.Rw == bus.Rb)) begin
        dout_b_d = bus.din;
      end else begin
        dout_b_d = mem_q[bus.Rb];
      end
    end
  end

  // Registered read ports: they clear asynchronously so that reset zeroes them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign bus.doutA   = dout_a_q;
  assign bus.doutB   = dout_b_q;
  assign bus.busy    = busy;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Bench for regfile_2r1w_clr. Two instances receive identical stimulus:
// u_main (ZERO_REG=1, BYPASS=1) and u_alt (ZERO_REG=0, BYPASS=0).
module tb_regfile_2r1w_clr;

  localparam int W = 64;
  localparam int A = 5;
  localparam int DEPTH = 32;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_2r1w_clr_if #(.DATA_W(W), .ADDR_W(A)) bus_m ();
  regfile_2r1w_clr_if #(.DATA_W(W), .ADDR_W(A)) bus_a ();
  logic dbg_m, dbg_a;

  regfile_2r1w_clr #(.DATA_W(W), .ADDR_W(A), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(bus_m.slave), .dbg_state_o(dbg_m)
  );
  regfile_2r1w_clr #(.DATA_W(W), .ADDR_W(A), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_alt (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .dbg_state_o(dbg_a)
  );

  typedef struct {
    logic         we;
    logic [A-1:0] rw;
    logic [W-1:0] din;
    logic [A-1:0] ra;
    logic [A-1:0] rb;
    logic [W-1:0] exp_a;   // u_main doutA
    logic [W-1:0] exp_b;   // u_main doutB
    logic [W-1:0] alt_a;   // u_alt doutA
    logic [W-1:0] alt_b;   // u_alt doutB
  } vec_t;

  vec_t vecs[12];
  logic [4*W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard check.
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: both instances receive the same inputs.
  task automatic drive(input logic we, input logic [A-1:0] rw, input logic [W-1:0] din,
                       input logic [A-1:0] ra, input logic [A-1:0] rb);
    bus_m.we = we; bus_m.Rw = rw; bus_m.din = din; bus_m.Ra = ra; bus_m.Rb = rb;
    bus_a.we = we; bus_a.Rw = rw; bus_a.din = din; bus_a.Ra = ra; bus_a.Rb = rb;
  endtask

  // Drive one vector, queue its expectation, and compare one posedge later.
  task automatic apply(input string tag, input vec_t v);
    logic [4*W-1:0] e;
    drive(v.we, v.rw, v.din, v.ra, v.rb);
    exp_q.push_back({v.exp_a, v.exp_b, v.alt_a, v.alt_b});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " main doutA"}, bus_m.doutA, e[4*W-1:3*W]);
      check({tag, " main doutB"}, bus_m.doutB, e[3*W-1:2*W]);
      check({tag, " alt doutA"},  bus_a.doutA, e[2*W-1:W]);
      check({tag, " alt doutB"},  bus_a.doutB, e[W-1:0]);
    end
  endtask

  // Count posedges while busy is high (bounded), checking that outputs stay 0.
  task automatic count_clear(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (bus_m.busy) begin
        check({tag, " doutA during clear"}, bus_m.doutA, '0);
        check({tag, " doutB during clear"}, bus_m.doutB, '0);
      end
    end while (bus_m.busy && n < 200);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b0, 5'd0,  64'h0,        5'd3,  5'd31, 64'h0,        64'h0,        64'h0,        64'h0};
    vecs[1]  = '{1'b1, 5'd5,  64'hDEADBEEF, 5'd1,  5'd2,  64'h0,        64'h0,        64'h0,        64'h0};
    vecs[2]  = '{1'b0, 5'd0,  64'h0,        5'd5,  5'd5,  64'hDEADBEEF, 64'hDEADBEEF, 64'hDEADBEEF, 64'hDEADBEEF};
    vecs[3]  = '{1'b1, 5'd7,  64'h1234,     5'd7,  5'd7,  64'h1234,     64'h1234,     64'h0,        64'h0};
    vecs[4]  = '{1'b1, 5'd0,  64'hFF,       5'd7,  5'd5,  64'h1234,     64'hDEADBEEF, 64'h1234,     64'hDEADBEEF};
    vecs[5]  = '{1'b0, 5'd0,  64'h0,        5'd0,  5'd0,  64'h0,        64'h0,        64'hFF,       64'hFF};
    vecs[6]  = '{1'b1, 5'd0,  64'h77,       5'd0,  5'd5,  64'h0,        64'hDEADBEEF, 64'hFF,       64'hDEADBEEF};
    vecs[7]  = '{1'b1, 5'd31, 64'hCAFE,     5'd31, 5'd0,  64'hCAFE,     64'h0,        64'h0,        64'h77};
    vecs[8]  = '{1'b1, 5'd5,  64'h1111,     5'd5,  5'd31, 64'h1111,     64'hCAFE,     64'hDEADBEEF, 64'hCAFE};
    vecs[9]  = '{1'b0, 5'd5,  64'h9999,     5'd5,  5'd7,  64'h1111,     64'h1234,     64'h1111,     64'h1234};
    vecs[10] = '{1'b1, 5'd9,  64'h55,       5'd9,  5'd1,  64'h55,       64'h0,        64'h0,        64'h0};
    vecs[11] = '{1'b0, 5'd0,  64'h0,        5'd9,  5'd3,  64'h55,       64'h0,        64'h55,       64'h0};

    // Reset state, with a write to r3 held throughout reset and clear.
    drive(1'b1, 5'd3, 64'hAA, 5'd3, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", W'(bus_m.busy), W'(1));
    check("reset doutA", bus_m.doutA, '0);
    check("reset doutB", bus_m.doutB, '0);
    check("reset state", W'(dbg_m), W'(0));
    rst_n = 1'b1;

    count_clear("clear1", n);
    check("clear1 busy posedges", W'(n), W'(DEPTH));
    check("clear1 state READY", W'(dbg_m), W'(1));

    // Read every entry: all zero after clear (r3's held write was dropped).
    for (int i = 0; i < DEPTH; i += 2) begin
      vec_t v;
      v = '{1'b0, 5'd0, 64'h0, A'(i), A'(i + 1), 64'h0, 64'h0, 64'h0, 64'h0};
      apply($sformatf("sweep r%0d", i), v);
    end

    for (int i = 0; i < 12; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset while doutA holds r9 = 0x55.
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst doutA", bus_m.doutA, '0);
    check("async rst alt doutA", bus_a.doutA, '0);
    check("async rst busy", W'(bus_m.busy), W'(1));
    #1;
    rst_n = 1'b1;

    // Reset again in the middle of clearing: clearing restarts from entry 0.
    repeat (10) @(posedge clk);
    #2;
    check("midclear busy", W'(bus_m.busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("midclear rst doutA", bus_m.doutA, '0);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 5'd9, 5'd5);
    count_clear("clear2", n);
    check("clear2 busy posedges", W'(n), W'(DEPTH));

    // Data written before reset is lost.
    begin
      vec_t v;
      v = '{1'b0, 5'd0, 64'h0, 5'd9, 5'd5, 64'h0, 64'h0, 64'h0, 64'h0};
      apply("post-reset r9/r5", v);
      v = '{1'b0, 5'd0, 64'h0, 5'd31, 5'd7, 64'h0, 64'h0, 64'h0, 64'h0};
      apply("post-reset r31/r7", v);
    end

    // Random writes and reads of distinct, non-zero entries (bypass off the path).
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      logic [A-1:0] r;
      logic [W-1:0] d;
      r = A'($urandom_range(1, DEPTH - 1));
      d = {$urandom, $urandom};
      v = '{1'b1, r, d, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0};
      apply($sformatf("rnd wr%0d", i), v);
      v = '{1'b0, 5'd0, 64'h0, r, r, d, d, d, d};
      apply($sformatf("rnd rd%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
